// File: rtl/lorenz_pkg.sv
// Shared types and screen constants for the Lorenz pixel streamer.
// Plane selection is enabled with the LORENZ_PLANE_SELECT_EN macro.
package lorenz_pkg;

  localparam int FX_W    = 27;
  localparam int FX_FRAC = 20;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int CX    = 320;
  localparam int CY    = 240;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
  } pix_t;

  typedef enum logic [1:0] {
    PLANE_XZ = 2'd0,
    PLANE_XY = 2'd1,
    PLANE_YZ = 2'd2
  } plane_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO: the head entry is visible on dout whenever empty is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Output forced to zero while empty so idle outputs read as zero.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lorenz_pixel_streamer.sv
// Decimates Lorenz solver samples, projects them to 640x480, clips and queues pixel writes.
// Define LORENZ_PLANE_SELECT_EN to add the plane_sel input (x-z, x-y, y-z).
module lorenz_pixel_streamer
  import lorenz_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DECIM = 4,
  parameter int SHIFT = 17,
  parameter int Z_OFF = 26214400
) (
  input  logic        clock,
  input  logic        reset,
`ifdef LORENZ_PLANE_SELECT_EN
  input  logic [1:0]  plane_sel,
`endif
  input  logic        sample_valid,
  input  fx_t         x,
  input  fx_t         y,
  input  fx_t         z,
  input  logic        clear,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [15:0] clip_cnt
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  localparam logic signed [27:0] ZOFF_W = 28'(Z_OFF);
  localparam logic signed [27:0] CX_W   = 28'(CX);
  localparam logic signed [27:0] CY_W   = 28'(CY);
  localparam logic signed [27:0] H_W    = 28'(H_RES);
  localparam logic signed [27:0] V_W    = 28'(V_RES);

  logic [DW-1:0] dec_cnt;
  logic          accept;

  fx_t  h_sel;
  fx_t  v_sel;
  logic vz_sel;

  logic s0_valid;
  fx_t  s0_h;
  fx_t  s0_v;
  logic s0_vz;

  logic signed [27:0] h_w;
  logic signed [27:0] v_w;
  logic signed [27:0] v_off;
  logic signed [27:0] col_w;
  logic signed [27:0] row_w;
  logic               on_screen;

  logic s1_keep;
  pix_t s1_pix;

  pix_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop_req;
  logic drop;

  assign accept = sample_valid && (dec_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (clear) begin
      dec_cnt <= '0;
    end else if (sample_valid) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DW'(1);
    end
  end

  // First variable drives columns, second drives rows; vz_sel marks a z row axis.
  always_comb begin
    h_sel  = x;
    v_sel  = z;
    vz_sel = 1'b1;
`ifdef LORENZ_PLANE_SELECT_EN
    case (plane_sel)
      PLANE_XY: begin
        v_sel  = y;
        vz_sel = 1'b0;
      end
      PLANE_YZ: h_sel = y;
      default:  ;
    endcase
`endif
  end

`ifndef LORENZ_PLANE_SELECT_EN
  logic unused_y;
  assign unused_y = ^y;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_h     <= '0;
      s0_v     <= '0;
      s0_vz    <= 1'b1;
    end else begin
      s0_valid <= accept && !clear;
      if (accept) begin
        s0_h  <= h_sel;
        s0_v  <= v_sel;
        s0_vz <= vz_sel;
      end
    end
  end

  assign h_w       = 28'(s0_h);
  assign v_w       = 28'(s0_v);
  assign v_off     = s0_vz ? (v_w - ZOFF_W) : v_w;
  assign col_w     = CX_W + (h_w >>> SHIFT);
  assign row_w     = CY_W - (v_off >>> SHIFT);
  // Range test on the full 28-bit results so wrapped values cannot alias on-screen.
  assign on_screen = (col_w >= 28'sd0) && (col_w < H_W) &&
                     (row_w >= 28'sd0) && (row_w < V_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_keep  <= 1'b0;
      s1_pix   <= '0;
      clip_cnt <= '0;
    end else if (clear) begin
      s1_keep  <= 1'b0;
      clip_cnt <= '0;
    end else begin
      s1_keep <= s0_valid && on_screen;
      if (s0_valid) begin
        s1_pix.col <= col_w[9:0];
        s1_pix.row <= row_w[8:0];
        if (!on_screen) begin
          clip_cnt <= sat_inc(clip_cnt);
        end
      end
    end
  end

  assign pop_req = pix_valid && pix_ready;
  assign drop    = s1_keep && fifo_full && !pop_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pix_t))
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .clear (clear),
    .push  (s1_keep),
    .din   (s1_pix),
    .pop   (pop_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign pix_x     = head.col;
  assign pix_y     = head.row;

endmodule
